// File: rtl/sys_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sys_bus_arbiter
// Brief    : Round-robin arbiter sharing one system bus between two requesters.
//            Optional ack timeout enabled by defining SYS_BUS_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module sys_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            sys_clk_i,
    input  logic            sys_rst_i,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic [DW-1:0]   m0_wdata_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_wen_i,
    input  logic            m0_ren_i,
    output logic [DW-1:0]   m0_rdata_o,
    output logic            m0_err_o,
    output logic            m0_ack_o,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW-1:0]   m1_wdata_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_wen_i,
    input  logic            m1_ren_i,
    output logic [DW-1:0]   m1_rdata_o,
    output logic            m1_err_o,
    output logic            m1_ack_o,
    output logic [AW-1:0]   sys_addr_o,
    output logic [DW-1:0]   sys_wdata_o,
    output logic [DW/8-1:0] sys_sel_o,
    output logic            sys_wen_o,
    output logic            sys_ren_o,
    input  logic [DW-1:0]   sys_rdata_i,
    input  logic            sys_err_i,
    input  logic            sys_ack_i
);
    localparam int SW = DW / 8;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
        $error("sys_bus_arbiter: TIMEOUT must be within 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0] in_addr  [2];
    logic [DW-1:0] in_wdata [2];
    logic [SW-1:0] in_sel   [2];
    logic [1:0]    in_req, in_we;

    logic [AW-1:0] lat_addr  [2];
    logic [DW-1:0] lat_wdata [2];
    logic [SW-1:0] lat_sel   [2];
    logic [1:0]    lat_we, pending;

    logic          last_grant, grant, cur_we, winner;
    logic          grant_go, done, timeout_hit, tmo;
    logic [DW-1:0] rsp_rdata [2];
    logic [1:0]    rsp_err, rsp_ack;

    assign in_addr[0]  = m0_addr_i;
    assign in_addr[1]  = m1_addr_i;
    assign in_wdata[0] = m0_wdata_i;
    assign in_wdata[1] = m1_wdata_i;
    assign in_sel[0]   = m0_sel_i;
    assign in_sel[1]   = m1_sel_i;
    assign in_req      = {m1_wen_i | m1_ren_i, m0_wen_i | m0_ren_i};
    assign in_we       = {m1_wen_i, m0_wen_i};

    // Tie goes to the requester that was not served last.
    always_comb begin
        winner = 1'b0;
        if (pending == 2'b10)
            winner = 1'b1;
        else if (pending == 2'b11)
            winner = ~last_grant;
    end

`ifdef SYS_BUS_ARB_TIMEOUT_EN
    localparam int TW = 16;
    logic [TW-1:0] timer;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i)
            timer <= '0;
        else if (grant_go)
            timer <= '0;
        else if (state != IDLE)
            timer <= timer + 1'b1;
    end

    assign tmo = (timer == TW'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A slave response in the same cycle as the timeout takes precedence.
    always_comb begin
        state_nxt   = state;
        grant_go    = 1'b0;
        done        = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    state_nxt = ISSUE;
                    grant_go  = 1'b1;
                end
            end
            ISSUE, WAIT: begin
                state_nxt = WAIT;
                if (sys_ack_i | sys_err_i) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo) begin
                    done        = 1'b1;
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            pending     <= 2'b00;
            lat_we      <= 2'b00;
            last_grant  <= 1'b1;
            grant       <= 1'b0;
            cur_we      <= 1'b0;
            sys_addr_o  <= '0;
            sys_wdata_o <= '0;
            sys_sel_o   <= '0;
            rsp_err     <= 2'b00;
            rsp_ack     <= 2'b00;
            for (int n = 0; n < 2; n++) begin
                lat_addr[n]  <= '0;
                lat_wdata[n] <= '0;
                lat_sel[n]   <= '0;
                rsp_rdata[n] <= '0;
            end
        end else begin
            // A pulse is only captured into an empty slot; a granted slot reopens.
            for (int n = 0; n < 2; n++) begin
                if (grant_go && (winner == n[0])) begin
                    pending[n] <= 1'b0;
                end else if (in_req[n] && !pending[n]) begin
                    pending[n]   <= 1'b1;
                    lat_addr[n]  <= in_addr[n];
                    lat_wdata[n] <= in_wdata[n];
                    lat_sel[n]   <= in_sel[n];
                    lat_we[n]    <= in_we[n];
                end
            end

            if (grant_go) begin
                sys_addr_o  <= lat_addr[winner];
                sys_wdata_o <= lat_wdata[winner];
                sys_sel_o   <= lat_sel[winner];
                cur_we      <= lat_we[winner];
                grant       <= winner;
                last_grant  <= winner;
            end

            rsp_ack <= 2'b00;
            if (done) begin
                rsp_ack[grant]   <= 1'b1;
                rsp_err[grant]   <= timeout_hit | sys_err_i;
                rsp_rdata[grant] <= (timeout_hit || cur_we) ? '0 : sys_rdata_i;
            end
        end
    end

    assign sys_wen_o  = (state == ISSUE) &  cur_we;
    assign sys_ren_o  = (state == ISSUE) & ~cur_we;
    assign m0_ack_o   = rsp_ack[0];
    assign m1_ack_o   = rsp_ack[1];
    assign m0_err_o   = rsp_err[0];
    assign m1_err_o   = rsp_err[1];
    assign m0_rdata_o = rsp_rdata[0];
    assign m1_rdata_o = rsp_rdata[1];

endmodule
`default_nettype wire

// File: tb/tb_sys_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_bus_arbiter
// Brief    : Self-checking bench for sys_bus_arbiter with a small memory slave.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sys_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m0_addr_i = '0, m0_wdata_i = '0, m1_addr_i = '0, m1_wdata_i = '0;
    logic [3:0]  m0_sel_i = '0, m1_sel_i = '0;
    logic        m0_wen_i = 1'b0, m0_ren_i = 1'b0, m1_wen_i = 1'b0, m1_ren_i = 1'b0;
    logic [31:0] m0_rdata_o, m1_rdata_o, sys_addr_o, sys_wdata_o;
    logic        m0_err_o, m0_ack_o, m1_err_o, m1_ack_o, sys_wen_o, sys_ren_o;
    logic [3:0]  sys_sel_o;
    logic [31:0] sys_rdata_i = '0;
    logic        sys_err_i = 1'b0, sys_ack_i = 1'b0;

    always #5 clk = ~clk;

    sys_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .sys_clk_i(clk), .sys_rst_i(rst),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_sel_i(m0_sel_i),
        .m0_wen_i(m0_wen_i), .m0_ren_i(m0_ren_i),
        .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o), .m0_ack_o(m0_ack_o),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_sel_i(m1_sel_i),
        .m1_wen_i(m1_wen_i), .m1_ren_i(m1_ren_i),
        .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o), .m1_ack_o(m1_ack_o),
        .sys_addr_o(sys_addr_o), .sys_wdata_o(sys_wdata_o), .sys_sel_o(sys_sel_o),
        .sys_wen_o(sys_wen_o), .sys_ren_o(sys_ren_o),
        .sys_rdata_i(sys_rdata_i), .sys_err_i(sys_err_i), .sys_ack_i(sys_ack_i)
    );

    typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] sel; } bus_t;
    typedef struct { logic [31:0] rdata; bit err; int cyc; } ack_t;
    typedef struct {
        int m; bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] sel;
        int delay; logic [31:0] rdata; bit err;
    } vec_t;

    bus_t bq[$];
    ack_t q0[$], q1[$];
    int checks = 0, errors = 0, cyc = 0, bus_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Slave: 0x14 never answers, 0x18 answers with an error, rest is a 16-word memory.
    logic [31:0] mem [16];
    int          slave_delay = 0, sl_cnt = -1;
    bit          sl_we;
    logic [31:0] sl_addr;
    always @(negedge clk) begin
        sys_ack_i = 1'b0; sys_err_i = 1'b0; sys_rdata_i = '0;
        if (sys_wen_o || sys_ren_o) begin
            sl_we = sys_wen_o; sl_addr = sys_addr_o; sl_cnt = slave_delay;
            if (sys_wen_o && sl_addr != 32'h14 && sl_addr != 32'h18)
                for (int b = 0; b < 4; b++)
                    if (sys_sel_o[b]) mem[sl_addr[5:2]][8*b +: 8] = sys_wdata_o[8*b +: 8];
        end
        if (sl_cnt == 0) begin
            sl_cnt = -1;
            if (sl_addr == 32'h18) begin
                sys_err_i = 1'b1; sys_rdata_i = 32'hDEAD0000;
            end else if (sl_addr != 32'h14) begin
                sys_ack_i = 1'b1; sys_rdata_i = sl_we ? 32'hBAD0BAD0 : mem[sl_addr[5:2]];
            end
        end else if (sl_cnt > 0) begin
            sl_cnt--;
        end
    end

    task automatic ack_seen(input int m, input logic [31:0] rd, input logic e);
        ack_t a;
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            checks++; errors++;
            $display("FAIL m%0d_ack_unexpected actual=ack rdata=%h required=no ack", m, rd);
        end else begin
            if (m == 0) a = q0.pop_front(); else a = q1.pop_front();
            check($sformatf("m%0d_rdata", m), rd, a.rdata);
            check($sformatf("m%0d_err", m), 32'(e), 32'(a.err));
            if (a.cyc >= 0) check($sformatf("m%0d_ack_cycle", m), cyc, a.cyc);
        end
    endtask

    always @(negedge clk) begin
        bus_t b;
        if (!rst) begin
            if (sys_wen_o || sys_ren_o) begin
                bus_pulses++;
                if (bq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_unexpected actual addr=%h required=no pulse", sys_addr_o);
                end else begin
                    b = bq.pop_front();
                    check("bus_addr", sys_addr_o, b.addr);
                    check("bus_wen", 32'(sys_wen_o), 32'(b.we));
                    if (b.we) begin
                        check("bus_wdata", sys_wdata_o, b.wdata);
                        check("bus_sel", 32'(sys_sel_o), 32'(b.sel));
                    end
                end
            end
            if (m0_ack_o) ack_seen(0, m0_rdata_o, m0_err_o);
            if (m1_ack_o) ack_seen(1, m1_rdata_o, m1_err_o);
        end
    end

    task automatic go(input int m, input bit we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        if (m == 0) begin
            m0_addr_i = a; m0_wdata_i = d; m0_sel_i = s; m0_wen_i = we; m0_ren_i = !we;
        end else begin
            m1_addr_i = a; m1_wdata_i = d; m1_sel_i = s; m1_wen_i = we; m1_ren_i = !we;
        end
    endtask

    task automatic stop_m(input int m);
        if (m == 0) begin m0_wen_i = 1'b0; m0_ren_i = 1'b0; end
        else begin m1_wen_i = 1'b0; m1_ren_i = 1'b0; end
    endtask

    task automatic exp_bus(input bit we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        bus_t b;
        b.we = we; b.addr = a; b.wdata = d; b.sel = s;
        bq.push_back(b);
    endtask

    task automatic exp_ack(input int m, input logic [31:0] rd, input bit e, input int c);
        ack_t a;
        a.rdata = rd; a.err = e; a.cyc = c;
        if (m == 0) q0.push_back(a); else q1.push_back(a);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((bq.size() + q0.size() + q1.size()) != 0 && n < 300) begin
            @(negedge clk); n++;
        end
        #1;
        check({name, "_outstanding"}, bq.size() + q0.size() + q1.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_ack(input int m);
        int n = 0;
        while (!(m == 0 ? m0_ack_o : m1_ack_o) && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL m%0d_ack_wait actual=no ack required=ack within 200 cycles", m);
        end
    endtask

    vec_t vec[9];

    initial begin
        int c, p;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[1] = 32'h12345678;
        mem[3] = 32'hC0C0C0C0;
        vec[0] = '{0, 1'b0, 32'h04, 32'h0,        4'hF, 3, 32'h12345678, 1'b0};
        vec[1] = '{1, 1'b1, 32'h08, 32'hA5A5A5A5, 4'hF, 0, 32'h0,        1'b0};
        vec[2] = '{1, 1'b0, 32'h08, 32'h0,        4'hF, 0, 32'hA5A5A5A5, 1'b0};
        vec[3] = '{0, 1'b1, 32'h08, 32'h11223344, 4'h5, 1, 32'h0,        1'b0};
        vec[4] = '{0, 1'b0, 32'h08, 32'h0,        4'hF, 2, 32'hA522A544, 1'b0};
        vec[5] = '{1, 1'b0, 32'h18, 32'h0,        4'hF, 0, 32'hDEAD0000, 1'b1};
        vec[6] = '{0, 1'b1, 32'h18, 32'h55AA55AA, 4'hF, 1, 32'h0,        1'b1};
        vec[7] = '{1, 1'b1, 32'h3C, 32'hFFFFFFFF, 4'h8, 5, 32'h0,        1'b0};
        vec[8] = '{1, 1'b0, 32'h3C, 32'h0,        4'hF, 4, 32'hFF000000, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_sys_addr", sys_addr_o, 0);
        check("reset_sys_wen", 32'(sys_wen_o), 0);
        check("reset_sys_ren", 32'(sys_ren_o), 0);
        check("reset_m0_ack", 32'(m0_ack_o), 0);
        check("reset_m1_ack", 32'(m1_ack_o), 0);
        check("reset_m1_rdata", m1_rdata_o, 0);
        rst = 1'b0;

        foreach (vec[i]) begin
            slave_delay = vec[i].delay;
            @(posedge clk); #1;
            c = cyc;
            exp_bus(vec[i].we, vec[i].addr, vec[i].wdata, vec[i].sel);
            exp_ack(vec[i].m, vec[i].rdata, vec[i].err, c + 3 + vec[i].delay);
            go(vec[i].m, vec[i].we, vec[i].addr, vec[i].wdata, vec[i].sel);
            @(posedge clk); #1;
            stop_m(vec[i].m);
            drain($sformatf("vec%0d", i));
        end
        repeat (3) @(posedge clk);
        #1;
        check("hold_m1_rdata", m1_rdata_o, 32'hFF000000);
        check("hold_m0_err", 32'(m0_err_o), 1);

        // Simultaneous write and read of the same word: m0 must go first.
        slave_delay = 0;
        @(posedge clk); #1;
        c = cyc;
        exp_bus(1'b1, 32'h00, 32'h66666666, 4'hF);
        exp_bus(1'b0, 32'h00, 32'h0, 4'hF);
        exp_ack(0, 32'h0, 1'b0, c + 3);
        exp_ack(1, 32'h66666666, 1'b0, c + 5);
        go(0, 1'b1, 32'h00, 32'h66666666, 4'hF);
        go(1, 1'b0, 32'h00, 32'h0, 4'hF);
        @(posedge clk); #1;
        stop_m(0); stop_m(1);
        drain("same_cycle");

        // Second pulse while still pending is dropped.
        p = bus_pulses;
        @(posedge clk); #1;
        c = cyc;
        exp_bus(1'b0, 32'h04, 32'h0, 4'hF);
        exp_ack(0, 32'h12345678, 1'b0, c + 3);
        go(0, 1'b0, 32'h04, 32'h0, 4'hF);
        @(posedge clk); #1;
        go(0, 1'b0, 32'h0C, 32'h0, 4'hF);
        @(posedge clk); #1;
        stop_m(0);
        drain("dup_pulse");
        repeat (10) @(posedge clk);
        #1;
        check("dup_pulse_count", bus_pulses - p, 1);

        // Requests during an in-flight transfer: tie after m0 served -> m1 first.
        slave_delay = 6;
        @(posedge clk); #1;
        c = cyc;
        exp_bus(1'b0, 32'h04, 32'h0, 4'hF);
        exp_bus(1'b0, 32'h0C, 32'h0, 4'hF);
        exp_bus(1'b0, 32'h08, 32'h0, 4'hF);
        exp_ack(0, 32'h12345678, 1'b0, c + 9);
        exp_ack(1, 32'hC0C0C0C0, 1'b0, c + 17);
        exp_ack(0, 32'hA522A544, 1'b0, c + 25);
        go(0, 1'b0, 32'h04, 32'h0, 4'hF);
        @(posedge clk); #1;
        stop_m(0);
        repeat (2) @(posedge clk);
        #1;
        go(0, 1'b0, 32'h08, 32'h0, 4'hF);
        go(1, 1'b0, 32'h0C, 32'h0, 4'hF);
        @(posedge clk); #1;
        stop_m(0); stop_m(1);
        drain("inflight");

        // Both requesters re-request on every ack: grants must alternate (m1 first).
        slave_delay = 2;
        for (int r = 0; r < 8; r++) begin
            exp_bus(1'b1, 32'h24, 32'h0B00 + r, 4'hF);
            exp_bus(1'b1, 32'h20, 32'h0A00 + r, 4'hF);
            exp_ack(0, 32'h0, 1'b0, -1);
            exp_ack(1, 32'h0, 1'b0, -1);
        end
        @(posedge clk); #1;
        fork
            for (int r = 0; r < 8; r++) begin
                if (r > 0) begin @(posedge clk); #1; end
                go(0, 1'b1, 32'h20, 32'h0A00 + r, 4'hF);
                @(posedge clk); #1;
                stop_m(0);
                wait_ack(0);
            end
            for (int r = 0; r < 8; r++) begin
                if (r > 0) begin @(posedge clk); #1; end
                go(1, 1'b1, 32'h24, 32'h0B00 + r, 4'hF);
                @(posedge clk); #1;
                stop_m(1);
                wait_ack(1);
            end
        join
        drain("round_robin");

`ifdef SYS_BUS_ARB_TIMEOUT_EN
        // Unmapped address: forced error after TIMEOUT cycles, then normal service.
        @(posedge clk); #1;
        c = cyc;
        exp_bus(1'b0, 32'h14, 32'h0, 4'hF);
        exp_ack(1, 32'h0, 1'b1, c + 18);
        go(1, 1'b0, 32'h14, 32'h0, 4'hF);
        @(posedge clk); #1;
        stop_m(1);
        drain("timeout");
        slave_delay = 1;
        @(posedge clk); #1;
        c = cyc;
        exp_bus(1'b0, 32'h04, 32'h0, 4'hF);
        exp_ack(0, 32'h12345678, 1'b0, c + 4);
        go(0, 1'b0, 32'h04, 32'h0, 4'hF);
        @(posedge clk); #1;
        stop_m(0);
        drain("after_timeout");
`endif

        // Reset while waiting on an unanswered transfer: no ack, then clean restart.
        @(posedge clk); #1;
        exp_bus(1'b0, 32'h14, 32'h0, 4'hF);
        go(0, 1'b0, 32'h14, 32'h0, 4'hF);
        @(posedge clk); #1;
        stop_m(0);
        repeat (4) @(posedge clk);
        #3;
        check("wait_sys_addr", sys_addr_o, 32'h14);
        rst = 1'b1;
        #1;
        check("async_rst_sys_addr", sys_addr_o, 0);
        check("async_rst_sys_ren", 32'(sys_ren_o), 0);
        check("async_rst_m0_ack", 32'(m0_ack_o), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        p = bus_pulses;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_idle_pulses", bus_pulses - p, 0);
        slave_delay = 1;
        @(posedge clk); #1;
        c = cyc;
        exp_bus(1'b0, 32'h04, 32'h0, 4'hF);
        exp_ack(1, 32'h12345678, 1'b0, c + 4);
        go(1, 1'b0, 32'h04, 32'h0, 4'hF);
        @(posedge clk); #1;
        stop_m(1);
        drain("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
